// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state encoding, direction constants and call-position helpers
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_DOOR_OPEN = 2'b00,
    ST_MOVE_DN   = 2'b01,
    ST_MOVE_UP   = 2'b10,
    ST_IDLE      = 2'b11
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Helpers work on a zero-extended vector: bit 0 is floor 1, fl is one-hot.
  localparam int MAX_FLOORS = 64;

  function automatic logic any_above(input logic [MAX_FLOORS-1:0] vec,
                                     input logic [MAX_FLOORS-1:0] fl);
    return |(vec & ~((fl << 1) - MAX_FLOORS'(1)));
  endfunction

  function automatic logic any_below(input logic [MAX_FLOORS-1:0] vec,
                                     input logic [MAX_FLOORS-1:0] fl);
    return |(vec & (fl - MAX_FLOORS'(1)));
  endfunction

endpackage

// File: rtl/elevator_call_reg.sv
// rtl/elevator_call_reg.sv - per-floor call latch bank, clear beats set, absorbed presses never latch
module elevator_call_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N:1]   set,
  input  logic [N:1]   clr,
  input  logic [N:1]   absorb,
  output logic [N:1]   pend
);

  logic [N:1] pend_q, pend_d;

  always_comb begin
    pend_d = (pend_q | (set & ~absorb)) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/elevator_ctrl_param.sv
// rtl/elevator_ctrl_param.sv - N-floor collective (SCAN) elevator controller with travel and door dwell timers
module elevator_ctrl_param
  import elevator_pkg::*;
#(
  parameter int N_FLOORS         = 8,
  parameter int DOOR_OPEN_CYCLES = 10,
  parameter int TRAVEL_CYCLES    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS:1]   btup,
  input  logic [N_FLOORS:1]   btdn,
  input  logic [N_FLOORS:1]   in_bt_floor,
  input  logic                door_hold,
  output logic [N_FLOORS:1]   floor,
  output logic [1:0]          state,
  output logic                led_state_up,
  output logic                led_state_dn,
  output logic                bt_door_open,
  output logic                bt_door_close,
  output logic [N_FLOORS:1]   pend_up,
  output logic [N_FLOORS:1]   pend_dn,
  output logic [N_FLOORS:1]   pend_car
);

  localparam int MAXC = (DOOR_OPEN_CYCLES > TRAVEL_CYCLES) ? DOOR_OPEN_CYCLES : TRAVEL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_OPEN_CYCLES - 1);
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);

  state_e              state_q, state_d;
  logic [N_FLOORS:1]   floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [CW-1:0]       travel_q, travel_d, dwell_q, dwell_d;

  logic [N_FLOORS:1]   up_set, dn_set, pend_all, svc_floor;
  logic [N_FLOORS:1]   clr_up, clr_dn, clr_car, abs_up, abs_dn, abs_car;
  logic                svc_dir, serve_dir, serve, reload;
  logic                car_here, up_here, dn_here, same_here, opp_here;
  logic                above_s, below_s, ahead_s, behind_s, stop_s, flip_s;

  // svc_floor is the floor being judged: the next floor while moving, else the current one.
  always_comb begin
    up_set           = btup;
    up_set[N_FLOORS] = 1'b0;
    dn_set           = btdn;
    dn_set[1]        = 1'b0;
    pend_all         = pend_up | pend_dn | pend_car;
    svc_floor        = floor_q;
    svc_dir          = dir_q;
    if (state_q == ST_MOVE_UP) begin
      svc_dir = DIR_UP;
      if (!floor_q[N_FLOORS]) svc_floor = floor_q << 1;
    end else if (state_q == ST_MOVE_DN) begin
      svc_dir = DIR_DN;
      if (!floor_q[1]) svc_floor = floor_q >> 1;
    end
    car_here  = |(pend_car & svc_floor);
    up_here   = |(pend_up & svc_floor);
    dn_here   = |(pend_dn & svc_floor);
    same_here = (svc_dir == DIR_UP) ? up_here : dn_here;
    opp_here  = (svc_dir == DIR_UP) ? dn_here : up_here;
    above_s   = any_above(MAX_FLOORS'(pend_all), MAX_FLOORS'(svc_floor));
    below_s   = any_below(MAX_FLOORS'(pend_all), MAX_FLOORS'(svc_floor));
    ahead_s   = (svc_dir == DIR_UP) ? above_s : below_s;
    behind_s  = (svc_dir == DIR_UP) ? below_s : above_s;
    stop_s    = car_here | same_here | (opp_here & ~ahead_s);
    flip_s    = opp_here & ~same_here & ~car_here;
    serve_dir = flip_s ? ~svc_dir : svc_dir;
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    travel_d = travel_q;
    dwell_d  = dwell_q;
    serve    = 1'b0;
    reload   = 1'b0;
    clr_up   = '0;
    clr_dn   = '0;
    clr_car  = '0;
    abs_up   = '0;
    abs_dn   = '0;
    abs_car  = '0;
    case (state_q)
      ST_IDLE: begin
        if (car_here | up_here | dn_here) begin
          state_d = ST_DOOR_OPEN;
          dwell_d = DOOR_LOAD;
          serve   = 1'b1;
        end else if (above_s && (dir_q == DIR_UP || !below_s)) begin
          state_d  = ST_MOVE_UP;
          dir_d    = DIR_UP;
          travel_d = TRAVEL_LOAD;
        end else if (below_s) begin
          state_d  = ST_MOVE_DN;
          dir_d    = DIR_DN;
          travel_d = TRAVEL_LOAD;
        end
      end
      ST_MOVE_UP, ST_MOVE_DN: begin
        if (travel_q != '0) begin
          travel_d = travel_q - CW'(1);
        end else begin
          floor_d = svc_floor;
          if (stop_s) begin
            state_d = ST_DOOR_OPEN;
            dwell_d = DOOR_LOAD;
            serve   = 1'b1;
          end else if (ahead_s) begin
            travel_d = TRAVEL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        abs_car = floor_q;
        if (dir_q == DIR_UP) abs_up = floor_q;
        else                 abs_dn = floor_q;
        reload = door_hold |
                 (|((in_bt_floor | ((dir_q == DIR_UP) ? up_set : dn_set)) & floor_q));
        if (reload) begin
          dwell_d = DOOR_LOAD;
        end else if (dwell_q == '0) begin
          state_d = ST_IDLE;
          if (!ahead_s && behind_s) dir_d = ~dir_q;
        end else begin
          dwell_d = dwell_q - CW'(1);
        end
      end
    endcase
    if (serve) begin
      clr_car = svc_floor;
      dir_d   = serve_dir;
      if (serve_dir == DIR_UP) clr_up = svc_floor;
      else                     clr_dn = svc_floor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      floor_q  <= N_FLOORS'(1);
      dir_q    <= DIR_UP;
      travel_q <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      travel_q <= travel_d;
      dwell_q  <= dwell_d;
    end
  end

  elevator_call_reg #(.N(N_FLOORS)) u_up (
    .clk(clk), .rst(rst), .set(up_set), .clr(clr_up), .absorb(abs_up), .pend(pend_up)
  );
  elevator_call_reg #(.N(N_FLOORS)) u_dn (
    .clk(clk), .rst(rst), .set(dn_set), .clr(clr_dn), .absorb(abs_dn), .pend(pend_dn)
  );
  elevator_call_reg #(.N(N_FLOORS)) u_car (
    .clk(clk), .rst(rst), .set(in_bt_floor), .clr(clr_car), .absorb(abs_car), .pend(pend_car)
  );

  assign floor         = floor_q;
  assign state         = state_q;
  assign led_state_up  = (state_q == ST_MOVE_UP);
  assign led_state_dn  = (state_q == ST_MOVE_DN);
  assign bt_door_open  = (state_q == ST_DOOR_OPEN);
  assign bt_door_close = (state_q != ST_DOOR_OPEN);

endmodule

// File: tb/tb_elevator_ctrl_param.sv
// tb/tb_elevator_ctrl_param.sv - directed self-checking bench for elevator_ctrl_param (8-floor and 2-floor builds)
module tb_elevator_ctrl_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, hold, hold2;
  logic [8:1] btup, btdn, car, floor, pend_up, pend_dn, pend_car;
  logic [1:0] state, state2;
  logic       led_up, led_dn, door_open, door_close;
  logic [2:1] btup2, btdn2, car2, floor2, pend_up2, pend_dn2, pend_car2;
  logic       led_up2, led_dn2, door_open2, door_close2;
  int         checks = 0;
  int         errors = 0;
  int         n_open;

  elevator_ctrl_param #(.N_FLOORS(8), .DOOR_OPEN_CYCLES(4), .TRAVEL_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .btup(btup), .btdn(btdn), .in_bt_floor(car), .door_hold(hold),
    .floor(floor), .state(state), .led_state_up(led_up), .led_state_dn(led_dn),
    .bt_door_open(door_open), .bt_door_close(door_close),
    .pend_up(pend_up), .pend_dn(pend_dn), .pend_car(pend_car)
  );

  elevator_ctrl_param #(.N_FLOORS(2), .DOOR_OPEN_CYCLES(4), .TRAVEL_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .btup(btup2), .btdn(btdn2), .in_bt_floor(car2), .door_hold(hold2),
    .floor(floor2), .state(state2), .led_state_up(led_up2), .led_state_dn(led_dn2),
    .bt_door_open(door_open2), .bt_door_close(door_close2),
    .pend_up(pend_up2), .pend_dn(pend_dn2), .pend_car(pend_car2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; btup = '0; btdn = '0; car = '0;
    hold2 = 1'b0; btup2 = '0; btdn2 = '0; car2 = '0;
    tick(2);
    chk("rst_floor", floor, 8'h01);
    chk("rst_state", state, 2'b11);
    chk("rst_pend", {pend_up, pend_dn, pend_car}, 24'h0);
    chk("rst_leds", {led_up, led_dn, door_open, door_close}, 4'b0001);
    rst = 1'b0;

    // single car call to floor 5
    car = 8'h10; tick(1); car = '0;
    chk("t1_latch", pend_car, 8'h10);
    chk("t1_idle", state, 2'b11);
    tick(1);
    chk("t1_move", state, 2'b10);
    chk("t1_leds_move", {led_up, led_dn, door_open, door_close}, 4'b1001);
    tick(11);
    chk("t1_floor4", floor, 8'h08);
    tick(1);
    chk("t1_floor5", floor, 8'h10);
    chk("t1_door", state, 2'b00);
    chk("t1_pend_clr", pend_car, 8'h00);
    chk("t1_leds_door", {led_up, led_dn, door_open, door_close}, 4'b0010);
    tick(3);
    chk("t1_door_last", state, 2'b00);
    tick(1);
    chk("t1_idle_after", state, 2'b11);

    // hall calls up@3 and down@6 from floor 1
    rst = 1'b1; tick(1); rst = 1'b0;
    btdn = 8'h20; btup = 8'h04; tick(1); btdn = '0; btup = '0;
    chk("t2_latch", {pend_up, pend_dn}, 16'h0420);
    tick(1);
    chk("t2_move", state, 2'b10);
    tick(6);
    chk("t2_stop3", {floor, state}, {8'h04, 2'b00});
    chk("t2_clr3", {pend_up, pend_dn}, 16'h0020);
    tick(4);
    chk("t2_idle3", state, 2'b11);
    tick(1);
    chk("t2_resume", state, 2'b10);
    tick(9);
    chk("t2_stop6", {floor, state}, {8'h20, 2'b00});
    chk("t2_clr6", pend_dn, 8'h00);
    tick(4);
    chk("t2_idle6", state, 2'b11);
    car = 8'h82; tick(1); car = '0;
    chk("t2_car_latch", pend_car, 8'h82);
    tick(1);
    chk("t2_dir_down", state, 2'b01);

    // down call at 4 passed on the way to car call at 7
    rst = 1'b1; tick(1); rst = 1'b0;
    car = 8'h40; tick(1); car = '0;
    tick(1);
    chk("t3_move", state, 2'b10);
    tick(4);
    btdn = 8'h08; tick(1); btdn = '0;
    chk("t3_latch", pend_dn, 8'h08);
    tick(4);
    chk("t3_pass4", {floor, state}, {8'h08, 2'b10});
    tick(9);
    chk("t3_stop7", {floor, state, pend_car}, {8'h40, 2'b00, 8'h00});
    tick(4);
    chk("t3_idle7", state, 2'b11);
    tick(1);
    chk("t3_move_dn", state, 2'b01);
    tick(9);
    chk("t3_stop4", {floor, state, pend_dn}, {8'h08, 2'b00, 8'h00});

    // door hold and absorbed car press at floor 3
    rst = 1'b1; tick(1); rst = 1'b0;
    car = 8'h04; tick(1); car = '0;
    tick(7);
    chk("t4_at3", {floor, state}, {8'h04, 2'b00});
    hold = 1'b1; n_open = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (state == 2'b00) n_open++;
    end
    hold = 1'b0;
    chk("t4_hold_open", n_open, 10);
    tick(3);
    chk("t4_release_open", state, 2'b00);
    tick(1);
    chk("t4_release_close", state, 2'b11);
    car = 8'h04; tick(1); car = '0;
    chk("t4_idle_latch", pend_car, 8'h04);
    tick(1);
    chk("t4_reopen", {state, pend_car}, {2'b00, 8'h00});
    tick(2);
    car = 8'h04; tick(1); car = '0;
    chk("t4_absorb", pend_car, 8'h00);
    tick(3);
    chk("t4_reload_open", state, 2'b00);
    tick(1);
    chk("t4_reload_close", state, 2'b11);

    // reset mid-travel above floor 6
    rst = 1'b1; tick(1); rst = 1'b0;
    car = 8'h80; btdn = 8'h02; tick(1); car = '0; btdn = '0;
    tick(17);
    chk("t5_pre", {floor, state}, {8'h20, 2'b10});
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t5_floor", floor, 8'h01);
    chk("t5_state", state, 2'b11);
    chk("t5_pend", {pend_up, pend_dn, pend_car}, 24'h0);

    // two-floor build: down call at the top floor
    btdn2 = 2'b11; tick(1); btdn2 = '0;
    chk("t6_latch", pend_dn2, 2'b10);
    tick(1);
    chk("t6_move", state2, 2'b10);
    tick(3);
    chk("t6_stop2", {floor2, state2, pend_dn2}, {2'b10, 2'b00, 2'b00});
    tick(4);
    chk("t6_idle2", {floor2, state2}, {2'b10, 2'b11});
    btup2 = 2'b10; tick(1); btup2 = '0;
    chk("t6_up_ignored", pend_up2, 2'b00);
    tick(1);
    chk("t6_no_overrun", {floor2, state2}, {2'b10, 2'b11});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
